reg_bus_arbiter: RTL
====================

Name: reg_bus_arbiter

Overview:
- Shares the single internal register bus between two requesters, each using a request/acknowledge handshake.
  - Port 0: SPI host path.
  - Port 1: internal sequencer/config loader.
- Drives the bus signals o_addr_bus, o_data_write_bus and o_wr_enable_bus, which feed the register bank, and samples i_data_read_bus.
- Arbitration is round-robin with optional bounded bursts.
- Every transaction is committed once granted and always completes with a one-cycle ack.

Parameters:
- READ_LATENCY, 1: cycles from address valid to i_data_read_bus valid; legal range 1..7.
- MAX_BURST, 4: maximum back-to-back transactions one locked requester may hold the bus for; legal range 1..15.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_req0  in  1  port 0 transaction request; level.
- i_lock0  in  1  port 0 requests to keep the grant for the next transaction.
- i_we0  in  1  port 0 direction: 1 = write, 0 = read.
- i_addr0  in  `ADDR_WIDTH  port 0 address.
- i_wdata0  in  `DATA_WIDTH  port 0 write data.
- o_ack0  out  1  port 0 transaction done; one-cycle pulse.
- o_rdata0  out  `DATA_WIDTH  port 0 read data; valid with o_ack0.
- i_req1, i_lock1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1: same as port 0, for port 1.
- i_data_read_bus  in  `DATA_WIDTH  register bank read data.
- o_addr_bus  out  `ADDR_WIDTH  bus address.
- o_data_write_bus  out  `DATA_WIDTH  bus write data.
- o_wr_enable_bus  out  1  bus write strobe.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Registered outputs: all outputs are registered.
- Reset values:
  - o_addr_bus = 8'hFF (IDLE_ADDR).
  - o_data_write_bus = 8'h00, o_wr_enable_bus = 0.
  - o_ack0 = o_ack1 = 0, o_rdata0 = o_rdata1 = 8'h00, o_busy = 0.
  - Round-robin pointer: last-granted = 1, so port 0 wins the first tie.
  - State = IDLE; burst counter = 0; wait counter = 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Bus outputs hold 8'hFF / 8'h00 / 0.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port that is not the last-granted one.
  - On a grant, latch the port id, i_we, i_addr and i_wdata; update the pointer; go to ACCESS.
  - Burst counter is cleared to 1.
- ACCESS (1 cycle):
  - o_addr_bus = latched address; o_data_write_bus = latched wdata.
  - o_wr_enable_bus = latched we; the write strobe is high for exactly this one cycle.
  - Next state: DONE for a write; WAIT for a read (wait counter loaded with READ_LATENCY-1).
- WAIT:
  - Address held on o_addr_bus; counter decrements.
  - When the counter is 0 and i_data_read_bus is valid, capture it into o_rdataN; go to DONE.
- DONE (1 cycle):
  - o_ackN pulses for the granted port only.
  - Bus outputs return to idle values.
  - Burst continuation: if the granted port has lock=1, req=1 and burst count < MAX_BURST:
    - re-latch that port's inputs, increment the burst count, go to ACCESS;
    - the other port is not considered and the pointer is unchanged.
  - Otherwise go to IDLE.
- Latency from the IDLE cycle that samples req high:
  - Write ack appears 2 cycles later.
  - Read ack appears 2+READ_LATENCY cycles later.
- Write data for a read: o_rdataN is left unchanged on writes.
- Requester rule: inputs must be stable from req until ack. A committed transaction completes even if req drops mid-transaction.
- A requester that keeps req high after ack issues a new transaction: through the burst path if locked, otherwise through IDLE arbitration.
- A burst limit of MAX_BURST reached with the other port requesting guarantees the other port the next grant.
- Reset mid-transaction:
  - Next edge forces the reset values.
  - No ack is issued; o_wr_enable_bus deasserts immediately.
  - A write already strobed is not undone.
- Simultaneous ack and new request from the other port: the request is handled in the following IDLE cycle. No ack ever overlaps between ports.

Decomposition:
- Constants added to address_map.vh:
  - IDLE_ADDR = 8'hFF.
  - Arbiter state encodings: 2-bit, IDLE=0, ACCESS=1, WAIT=2, DONE=3.
- Sub-module arb_rr_pick: 2-requester round-robin picker.
  - Holds the last-granted pointer register.
  - Inputs: req[1:0], advance. Outputs: grant id, valid.

Test Plan:
- Single write: port 0 write, addr 8'h05, data 8'hA5.
  - Expect ACCESS with o_addr_bus = 05, o_data_write_bus = A5 and o_wr_enable_bus high for exactly 1 cycle.
  - Expect o_ack0 2 cycles after req sampled.
- Single read, READ_LATENCY = 1: port 1 read, addr 8'h10, bank returns 8'h3C.
  - Expect o_wr_enable_bus never high.
  - Expect o_ack1 3 cycles after req with o_rdata1 = 3C.
- Contention: both ports request continuously, unlocked.
  - Expect grants 0,1,0,1 and acks strictly alternating, never simultaneous.
- Burst limit: port 1 lock=1, req held, MAX_BURST = 4, port 0 requesting.
  - Expect 4 consecutive port 1 transactions without an IDLE cycle, then port 0 granted.
- Reset mid-read: i_rst asserted during WAIT.
  - Expect the next cycle o_addr_bus = FF, o_busy = 0, no ack.
  - Expect the next request after reset granted to port 0 on a tie.
- Request withdrawn: port 0 drops req the cycle after grant.
  - Expect the transaction to complete and o_ack0 to still pulse once.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_bus_arbiter_pkg
// Brief    : Shared constants, state encoding and transaction record for the
//            register bus arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_bus_arbiter_pkg;

   localparam int C_ADDR_WIDTH = 8;
   localparam int C_DATA_WIDTH = 8;

   localparam logic [C_ADDR_WIDTH-1:0] C_IDLE_ADDR = 8'hFF;
   localparam logic [C_DATA_WIDTH-1:0] C_IDLE_DATA = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic                    port;
      logic                    we;
      logic [C_ADDR_WIDTH-1:0] addr;
      logic [C_DATA_WIDTH-1:0] wdata;
   } txn_t;

   function automatic txn_t make_txn(input logic                    port,
                                     input logic                    we,
                                     input logic [C_ADDR_WIDTH-1:0] addr,
                                     input logic [C_DATA_WIDTH-1:0] wdata);
      txn_t t;
      t.port  = port;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bus_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : arb_rr_pick
// Brief    : Two-requester round-robin picker holding the last-granted pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr_pick (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic       o_grant,
   output logic       o_valid
);

   logic r_last;

   // On a tie the port that was not granted last wins.
   always_comb begin
      o_valid = |i_req;
      o_grant = 1'b0;
      case (i_req)
         2'b10:   o_grant = 1'b1;
         2'b11:   o_grant = ~r_last;
         default: o_grant = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (i_advance && o_valid) begin
         r_last <= o_grant;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reg_bus_arbiter
// Brief    : Round-robin arbiter sharing the register bus between the SPI host
//            path (port 0) and the sequencer/config loader (port 1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_bus_arbiter
   import reg_bus_arbiter_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST    = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req0,
   input  logic                    i_lock0,
   input  logic                    i_we0,
   input  logic [C_ADDR_WIDTH-1:0] i_addr0,
   input  logic [C_DATA_WIDTH-1:0] i_wdata0,
   output logic                    o_ack0,
   output logic [C_DATA_WIDTH-1:0] o_rdata0,
   input  logic                    i_req1,
   input  logic                    i_lock1,
   input  logic                    i_we1,
   input  logic [C_ADDR_WIDTH-1:0] i_addr1,
   input  logic [C_DATA_WIDTH-1:0] i_wdata1,
   output logic                    o_ack1,
   output logic [C_DATA_WIDTH-1:0] o_rdata1,
   input  logic [C_DATA_WIDTH-1:0] i_data_read_bus,
   output logic [C_ADDR_WIDTH-1:0] o_addr_bus,
   output logic [C_DATA_WIDTH-1:0] o_data_write_bus,
   output logic                    o_wr_enable_bus,
   output logic                    o_busy
);

   localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);
   localparam logic [2:0] C_WAIT_INIT = 3'(READ_LATENCY - 1);

   arb_state_t              r_state, w_state_nxt;
   txn_t                    r_txn, w_txn_nxt;
   logic [3:0]              r_burst, w_burst_nxt;
   logic [2:0]              r_wait, w_wait_nxt;

   logic [C_ADDR_WIDTH-1:0] w_addr_nxt;
   logic [C_DATA_WIDTH-1:0] w_wdata_nxt;
   logic                    w_we_nxt;
   logic                    w_ack0_nxt, w_ack1_nxt;
   logic [C_DATA_WIDTH-1:0] w_rdata0_nxt, w_rdata1_nxt;
   logic                    w_busy_nxt;

   txn_t                    w_txn0, w_txn1, w_txn_pick, w_txn_cont;
   logic                    w_grant, w_grant_valid, w_advance;
   logic                    w_req_g, w_lock_g;

   assign w_txn0     = make_txn(1'b0, i_we0, i_addr0, i_wdata0);
   assign w_txn1     = make_txn(1'b1, i_we1, i_addr1, i_wdata1);
   assign w_txn_pick = w_grant    ? w_txn1 : w_txn0;
   assign w_txn_cont = r_txn.port ? w_txn1 : w_txn0;
   assign w_req_g    = r_txn.port ? i_req1  : i_req0;
   assign w_lock_g   = r_txn.port ? i_lock1 : i_lock0;
   assign w_advance  = (r_state == ST_IDLE);

   arb_rr_pick u_pick (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     ({i_req1, i_req0}),
      .i_advance (w_advance),
      .o_grant   (w_grant),
      .o_valid   (w_grant_valid)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_txn_nxt    = r_txn;
      w_burst_nxt  = r_burst;
      w_wait_nxt   = r_wait;
      w_addr_nxt   = C_IDLE_ADDR;
      w_wdata_nxt  = C_IDLE_DATA;
      w_we_nxt     = 1'b0;
      w_ack0_nxt   = 1'b0;
      w_ack1_nxt   = 1'b0;
      w_rdata0_nxt = o_rdata0;
      w_rdata1_nxt = o_rdata1;

      case (r_state)
         ST_IDLE: begin
            w_burst_nxt = 4'd1;
            if (w_grant_valid) begin
               w_txn_nxt   = w_txn_pick;
               w_state_nxt = ST_ACCESS;
               w_addr_nxt  = w_txn_pick.addr;
               w_wdata_nxt = w_txn_pick.wdata;
               w_we_nxt    = w_txn_pick.we;
            end
         end
         ST_ACCESS: begin
            if (r_txn.we) begin
               w_state_nxt = ST_DONE;
               w_ack0_nxt  = ~r_txn.port;
               w_ack1_nxt  = r_txn.port;
            end else begin
               w_state_nxt = ST_WAIT;
               w_wait_nxt  = C_WAIT_INIT;
               w_addr_nxt  = r_txn.addr;
               w_wdata_nxt = r_txn.wdata;
            end
         end
         ST_WAIT: begin
            w_addr_nxt  = r_txn.addr;
            w_wdata_nxt = r_txn.wdata;
            if (r_wait == 3'd0) begin
               w_state_nxt = ST_DONE;
               w_ack0_nxt  = ~r_txn.port;
               w_ack1_nxt  = r_txn.port;
               if (r_txn.port) begin
                  w_rdata1_nxt = i_data_read_bus;
               end else begin
                  w_rdata0_nxt = i_data_read_bus;
               end
            end else begin
               w_wait_nxt = r_wait - 3'd1;
            end
         end
         ST_DONE: begin
            // Locked continuation skips arbitration and leaves the pointer alone.
            if (w_lock_g && w_req_g && (r_burst < C_MAX_BURST)) begin
               w_txn_nxt   = w_txn_cont;
               w_burst_nxt = r_burst + 4'd1;
               w_state_nxt = ST_ACCESS;
               w_addr_nxt  = w_txn_cont.addr;
               w_wdata_nxt = w_txn_cont.wdata;
               w_we_nxt    = w_txn_cont.we;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= ST_IDLE;
         r_txn            <= '0;
         r_burst          <= 4'd0;
         r_wait           <= 3'd0;
         o_addr_bus       <= C_IDLE_ADDR;
         o_data_write_bus <= C_IDLE_DATA;
         o_wr_enable_bus  <= 1'b0;
         o_ack0           <= 1'b0;
         o_ack1           <= 1'b0;
         o_rdata0         <= '0;
         o_rdata1         <= '0;
         o_busy           <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_txn            <= w_txn_nxt;
         r_burst          <= w_burst_nxt;
         r_wait           <= w_wait_nxt;
         o_addr_bus       <= w_addr_nxt;
         o_data_write_bus <= w_wdata_nxt;
         o_wr_enable_bus  <= w_we_nxt;
         o_ack0           <= w_ack0_nxt;
         o_ack1           <= w_ack1_nxt;
         o_rdata0         <= w_rdata0_nxt;
         o_rdata1         <= w_rdata1_nxt;
         o_busy           <= w_busy_nxt;
      end
   end

endmodule

`default_nettype wire
